// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes and clear-FSM state encoding shared by the register file
package regfile_pkg;
  localparam int N_DEF = 32;
  localparam int DEPTH_DEF = 16;
  localparam int NRD_DEF = 3;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
endpackage

// File: rtl/register_file_mp_reg_word.sv
// reg_word: one N-bit storage word with load enable and asynchronous reset
module reg_word
  import regfile_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);
  // Hold value unless enabled; reset clears immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) q_o <= '0;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with PC alias and bulk clear; REGFILE_BYPASS_EN enables write-to-read forwarding
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NRD = NRD_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_a,
  input  logic [AW-1:0]           wa_a,
  input  logic [N-1:0]            wd_a,
  input  logic                    we_b,
  input  logic [AW-1:0]           wa_b,
  input  logic [N-1:0]            wd_b,
  input  logic [NRD-1:0][AW-1:0]  ra,
  output logic [NRD-1:0][N-1:0]   rd,
  input  logic [N-1:0]            pc_in,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done
);
  localparam logic [AW-1:0] PC_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 2);
  clr_state_e state_q;
  logic [AW-1:0] idx_q;
  logic busy_q, done_q;
  logic [N-1:0] words [DEPTH];
  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign words[DEPTH-1] = pc_in;
  // Stored words; the PC slot has no storage, so writes to it never match
  for (genvar j = 0; j < DEPTH - 1; j++) begin : g_word
    logic hit_a, hit_b, hit_c;
    assign hit_a = !busy_q && we_a && wa_a == AW'(j);
    assign hit_b = !busy_q && we_b && wa_b == AW'(j);
    assign hit_c = state_q == CLEAR && idx_q == AW'(j);
    reg_word #(.N(N)) u_word (
      .clk  (clk),
      .rst  (rst),
      .en_i (hit_a | hit_b | hit_c),
      .d_i  (hit_c ? '0 : hit_b ? wd_b : wd_a),
      .q_o  (words[j])
    );
  end
  // Combinational read mux; forwarding skips the PC slot and is off during a clear
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_BYPASS_EN
      rd[i] = (!busy_q && ra[i] != PC_IDX && we_b && wa_b == ra[i]) ? wd_b :
              (!busy_q && ra[i] != PC_IDX && we_a && wa_a == ra[i]) ? wd_a : words[ra[i]];
`else
      rd[i] = words[ra[i]];
`endif
    end
  end
  // Clear sequencer: IDLE -> CLEAR (one word per cycle) -> DONE pulse -> IDLE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (clr_req) begin
          state_q <= CLEAR;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
        CLEAR: if (idx_q == LAST_IDX) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else idx_q <= idx_q + 1'b1;
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule
